// File: rtl/axi_llc_pkg.sv
// Shared types for the LLC SRAM scheduler.
package axi_llc_pkg;

  typedef enum logic [1:0] {
    INIT,
    RUN,
    DRAIN
  } sram_sched_state_e;

endpackage

// File: rtl/axi_llc_sram_sched_if.sv
// Requester-side and SRAM-side bundle of the LLC SRAM scheduler.
interface axi_llc_sram_sched_if #(
  parameter int unsigned NumPorts  = 3,
  parameter int unsigned AddrWidth = 10,
  parameter int unsigned DataWidth = 128,
  parameter int unsigned BeWidth   = 16
);
  logic [NumPorts-1:0]                req_i;
  logic [NumPorts-1:0]                we_i;
  logic [NumPorts-1:0][AddrWidth-1:0] addr_i;
  logic [NumPorts-1:0][DataWidth-1:0] wdata_i;
  logic [NumPorts-1:0][BeWidth-1:0]   be_i;
  logic [NumPorts-1:0]                gnt_o;
  logic [NumPorts-1:0]                rvalid_o;
  logic [DataWidth-1:0]               rdata_o;
  logic                               init_req_i;
  logic                               init_done_o;
  logic                               sram_req_o;
  logic                               sram_we_o;
  logic [AddrWidth-1:0]               sram_addr_o;
  logic [DataWidth-1:0]               sram_wdata_o;
  logic [BeWidth-1:0]                 sram_be_o;
  logic                               sram_gnt_i;
  logic [DataWidth-1:0]               sram_rdata_i;

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, be_i, init_req_i, sram_gnt_i, sram_rdata_i,
    output gnt_o, rvalid_o, rdata_o, init_done_o,
           sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o
  );

  modport master (
    output req_i, we_i, addr_i, wdata_i, be_i, init_req_i, sram_gnt_i, sram_rdata_i,
    input  gnt_o, rvalid_o, rdata_o, init_done_o,
           sram_req_o, sram_we_o, sram_addr_o, sram_wdata_o, sram_be_o
  );
endinterface

// File: rtl/axi_llc_sram_sched_rsp_pipe.sv
// Tag pipe matching the SRAM read latency: carries {valid, requester idx}.
module axi_llc_sram_rsp_pipe #(
  parameter int unsigned Latency  = 1,
  parameter int unsigned IdxWidth = 1
) (
  input  logic                clk_i,
  input  logic                clr_i,
  input  logic                vld_i,
  input  logic [IdxWidth-1:0] idx_i,
  output logic                vld_o,
  output logic [IdxWidth-1:0] idx_o,
  output logic                empty_o
);
  logic [Latency-1:0]               vld_q;
  logic [Latency-1:0][IdxWidth-1:0] idx_q;
  logic [Latency:0]                 vld_pipe;
  logic [Latency:0][IdxWidth-1:0]   idx_pipe;

  assign vld_pipe = {vld_q, vld_i};
  assign idx_pipe = {idx_q, idx_i};

  always_ff @(posedge clk_i) begin
    if (clr_i) vld_q <= '0;
    else       vld_q <= vld_pipe[Latency-1:0];
    idx_q <= idx_pipe[Latency-1:0];
  end

  assign vld_o   = vld_pipe[Latency];
  assign idx_o   = idx_pipe[Latency];
  assign empty_o = ~|vld_q;
endmodule

// File: rtl/axi_llc_sram_sched.sv
// Round-robin scheduler sharing one LLC SRAM port between requesters,
// with read-response routing and a zero-init sweep.
module axi_llc_sram_sched import axi_llc_pkg::*; #(
  parameter int unsigned NumPorts    = 3,
  parameter int unsigned NumWords    = 1024,
  parameter int unsigned DataWidth   = 128,
  parameter int unsigned ByteWidth   = 8,
  parameter int unsigned Latency     = 1,
  parameter bit          InitOnReset = 1'b1
) (
  input logic             clk_i,
  input logic             rst_i,
  axi_llc_sram_sched_if.slave bus
);
  localparam int unsigned AddrWidth = NumWords > 1 ? $clog2(NumWords) : 1;
  localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth;
  localparam int unsigned IdxWidth  = NumPorts > 1 ? $clog2(NumPorts) : 1;
  localparam sram_sched_state_e RstState = InitOnReset ? INIT : RUN;

  typedef logic [AddrWidth-1:0] addr_t;
  typedef logic [DataWidth-1:0] data_t;
  typedef logic [BeWidth-1:0]   be_t;
  typedef logic [IdxWidth-1:0]  idx_t;

  sram_sched_state_e state_q, state_d;
  addr_t init_cnt_q, init_cnt_d;
  idx_t  rr_ptr_q, lock_idx_q, arb_idx, win_idx, pop_idx, k;
  logic  lock_q, arb_vld, win_vld, accept, pop_vld, pipe_empty;

  // First active request at or after the priority pointer.
  always_comb begin
    arb_vld = 1'b0;
    arb_idx = '0;
    k       = '0;
    for (int i = NumPorts - 1; i >= 0; i--) begin
      k = idx_t'((int'(rr_ptr_q) + i) % int'(NumPorts));
      if (bus.req_i[k]) begin
        arb_vld = 1'b1;
        arb_idx = k;
      end
    end
  end

  // A stalled winner stays locked so a late higher-priority request cannot steal the slot.
  assign win_vld = lock_q | arb_vld;
  assign win_idx = lock_q ? lock_idx_q : arb_idx;

  always_comb begin
    state_d          = state_q;
    init_cnt_d       = init_cnt_q;
    accept           = 1'b0;
    bus.gnt_o        = '0;
    bus.sram_req_o   = 1'b0;
    bus.sram_we_o    = 1'b0;
    bus.sram_addr_o  = addr_t'(0);
    bus.sram_wdata_o = data_t'(0);
    bus.sram_be_o    = be_t'(0);
    unique case (state_q)
      INIT: begin
        bus.sram_req_o   = 1'b1;
        bus.sram_we_o    = 1'b1;
        bus.sram_be_o    = '1;
        bus.sram_addr_o  = init_cnt_q;
        if (bus.sram_gnt_i) begin
          if (init_cnt_q == addr_t'(NumWords - 1)) begin
            init_cnt_d = '0;
            state_d    = RUN;
          end else begin
            init_cnt_d = init_cnt_q + addr_t'(1);
          end
        end
      end
      RUN: begin
        bus.sram_req_o     = win_vld;
        bus.sram_we_o      = bus.we_i[win_idx];
        bus.sram_addr_o    = bus.addr_i[win_idx];
        bus.sram_wdata_o   = bus.wdata_i[win_idx];
        bus.sram_be_o      = bus.be_i[win_idx];
        bus.gnt_o[win_idx] = win_vld & bus.sram_gnt_i;
        accept             = win_vld & bus.sram_gnt_i;
        if (bus.init_req_i) state_d = DRAIN;
      end
      DRAIN: if (pipe_empty) state_d = INIT;
      default: state_d = RstState;
    endcase
    if (rst_i) begin
      bus.sram_req_o = 1'b0;
      bus.gnt_o      = '0;
      accept         = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= RstState;
      init_cnt_q <= '0;
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      if (accept) rr_ptr_q <= (win_idx == idx_t'(NumPorts - 1)) ? '0 : win_idx + idx_t'(1);
      lock_q     <= (state_q == RUN) && win_vld && !bus.sram_gnt_i;
      lock_idx_q <= win_idx;
    end
  end

  axi_llc_sram_rsp_pipe #(
    .Latency  (Latency),
    .IdxWidth (IdxWidth)
  ) i_rsp_pipe (
    .clk_i   (clk_i),
    .clr_i   (rst_i),
    .vld_i   (accept & ~bus.we_i[win_idx]),
    .idx_i   (win_idx),
    .vld_o   (pop_vld),
    .idx_o   (pop_idx),
    .empty_o (pipe_empty)
  );

  always_comb begin
    bus.rvalid_o = '0;
    if (pop_vld && !rst_i) bus.rvalid_o[pop_idx] = 1'b1;
  end

  assign bus.rdata_o     = bus.sram_rdata_i;
  assign bus.init_done_o = rst_i ? !InitOnReset : (state_q == RUN);
endmodule
